// File: rtl/serial_right_shifter.sv
// Multi-cycle right shifter (logical/arithmetic) with start/done handshake, one bit per clock.
// Define SERIAL_RIGHT_SHIFTER_FAST_EN to shift by 4 per clock while at least 4 positions remain.
module serial_right_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state;
    logic signed [WIDTH-1:0]   work;
    logic        [SHAMT_W-1:0] count;
    logic                      mode;

    // The fill bit is the sign bit only for arithmetic shifts.
    function automatic logic signed [WIDTH-1:0] shr1(input logic signed [WIDTH-1:0] w,
                                                     input logic m);
        return {m & w[WIDTH-1], w[WIDTH-1:1]};
    endfunction

    function automatic logic signed [WIDTH-1:0] shr4(input logic signed [WIDTH-1:0] w,
                                                     input logic m);
        return {{4{m & w[WIDTH-1]}}, w[WIDTH-1:4]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            work  <= '0;
            count <= '0;
            mode  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work  <= in;
                        count <= shamt;
                        mode  <= arith;
                        state <= SHIFT;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
`ifdef SERIAL_RIGHT_SHIFTER_FAST_EN
                        if (count > SHAMT_W'(3)) begin
                            work  <= shr4(work, mode);
                            count <= count - SHAMT_W'(4);
                        end else begin
                            work  <= shr1(work, mode);
                            count <= count - SHAMT_W'(1);
                        end
`else
                        work  <= shr1(work, mode);
                        count <= count - SHAMT_W'(1);
`endif
                    end else begin
                        out   <= work;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_right_shifter.sv
// Directed and random checks for serial_right_shifter (either macro build).
module tb_serial_right_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] din;
    logic [4:0]  shamt_v;
    logic        arith_v;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int checks   = 0;
    int failures = 0;

    serial_right_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (din),
        .shamt (shamt_v),
        .arith (arith_v),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .out   (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shr(input logic [31:0] a, input logic [4:0] s,
                                            input logic ar);
        logic signed [31:0] sa;
        sa = a;
        return ar ? 32'(sa >>> s) : (a >> s);
    endfunction

    function automatic int shift_cycles(input logic [4:0] s);
`ifdef SERIAL_RIGHT_SHIFTER_FAST_EN
        return int'(s) / 4 + int'(s) % 4;
`else
        return int'(s);
`endif
    endfunction

    // Accept one request and follow it to completion, checking latency, busy length,
    // out stability during the shift, the result and the one-cycle done pulse.
    task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic ar,
                          input string tag);
        logic [31:0] exp;
        logic [31:0] prev;
        int          edges;
        int          busyc;
        int          waitc;
        bit          stable;
        exp   = ref_shr(a, s, ar);
        waitc = 0;
        while (!ready && waitc < 50) begin
            step();
            waitc++;
        end
        prev    = dout;
        start   = 1'b1;
        din     = a;
        shamt_v = s;
        arith_v = ar;
        step();
        start   = 1'b0;
        din     = $urandom;
        shamt_v = 5'($urandom);
        arith_v = 1'($urandom);
        edges   = 0;
        busyc   = 0;
        stable  = 1'b1;
        while (!done && edges < 80) begin
            if (busy) busyc++;
            if (dout !== prev) stable = 1'b0;
            step();
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges + 1), 32'(shift_cycles(s) + 2));
        chk({tag, "_busy_cycles"}, 32'(busyc), 32'(shift_cycles(s) + 1));
        chk({tag, "_out_stable"}, 32'(stable), 32'd1);
        chk({tag, "_out"}, dout, exp);
        step();
        chk({tag, "_done_width"}, 32'(done), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int          dones;
        logic [31:0] r_in;
        logic [4:0]  r_sh;
        logic        r_ar;

        reset   = 1'b1;
        start   = 1'b0;
        din     = '0;
        shamt_v = '0;
        arith_v = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", dout, 32'd0);
        reset = 1'b0;
        step();

        // 1: logical shift
        run_op(32'hF000_0000, 5'd4, 1'b0, "t1_srl4");
        chk("t1_value", dout, 32'h0F00_0000);

        // 2: arithmetic / logical full-width shift
        run_op(32'h8000_0000, 5'd31, 1'b1, "t2_sra31");
        chk("t2_sra_value", dout, 32'hFFFF_FFFF);
        run_op(32'h8000_0000, 5'd31, 1'b0, "t2_srl31");
        chk("t2_srl_value", dout, 32'h0000_0001);

        // 3: zero shift, then start held high across busy/done
        start   = 1'b1;
        din     = 32'h1234_5678;
        shamt_v = 5'd0;
        arith_v = 1'b0;
        step();
        din     = 32'hAAAA_5555;
        shamt_v = 5'd1;
        chk("t3_busy", 32'(busy), 32'd1);
        step();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_out", dout, 32'h1234_5678);
        step();
        chk("t3_ready", 32'(ready), 32'd1);
        chk("t3_idle_busy", 32'(busy), 32'd0);
        step();
        chk("t3_second_accept", 32'(busy), 32'd1);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) dones++;
        end
        chk("t3_second_dones", 32'(dones), 32'd1);
        chk("t3_second_out", dout, 32'h5555_2AAA);

        // 4: start during busy is ignored
        start   = 1'b1;
        din     = 32'hFFFF_0000;
        shamt_v = 5'd8;
        arith_v = 1'b0;
        step();
        din     = 32'h0000_0001;
        shamt_v = 5'd1;
        step();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            step();
        end
        chk("t4_dones", 32'(dones), 32'd1);
        chk("t4_out", dout, 32'h00FF_FF00);
        chk("t4_idle", 32'(ready), 32'd1);

        // 5: asynchronous reset mid-operation
        start   = 1'b1;
        din     = 32'hDEAD_BEEF;
        shamt_v = 5'd20;
        arith_v = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t5_pre_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_ready", 32'(ready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_out", dout, 32'd0);
        step();
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dones++;
        end
        chk("t5_no_done", 32'(dones), 32'd0);
        run_op(32'h0000_0100, 5'd8, 1'b0, "t5_after");
        chk("t5_after_value", dout, 32'h0000_0001);

        // 6: random regression against the >> / >>> reference
        for (int i = 0; i < 1000; i++) begin
            r_in = $urandom;
            r_sh = 5'($urandom);
            r_ar = 1'($urandom);
            run_op(r_in, r_sh, r_ar, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_right_shifter.md
Name: serial_right_shifter

Overview:
Multi-cycle 32-bit right shifter for the datapath's SRL/SRA/SRLV/SRAV instructions. It is the opposite-direction companion to the fixed left-by-2 branch-offset shifter.
Takes an operand, a shift amount and a mode, shifts one bit per clock, and returns the result with a start/done handshake.
The control FSM stalls the pipeline on busy.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while ready=1
in  input  WIDTH  operand, captured when start is accepted
shamt  input  SHAMT_W  shift amount, captured when start is accepted
arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); captured at accept
ready  output  1  high only in IDLE
busy  output  1  high only in SHIFT
done  output  1  one-cycle pulse; out is valid in that cycle
out  output  WIDTH  result register; holds until the next accepted start completes

Behaviour:
- Reset (asynchronous, any state, including mid-shift):
  - state=IDLE, ready=1, busy=0, done=0, out=0.
  - Working register and counter cleared; in-flight operation discarded, no done pulse.
- States:
  - IDLE: ready=1. On start=1, capture in->work, shamt->count, arith->mode; go to SHIFT.
  - SHIFT: busy=1.
    - If count!=0: work <= {fill, work[WIDTH-1:1]}, count <= count-1. fill = mode ? work[WIDTH-1] : 0.
    - If count==0: out <= work; go to DONE.
  - DONE: done=1 for exactly one cycle, ready=0. Unconditionally go to IDLE.
- Latency, with the accept edge as edge 0:
  - done is high in the cycle after edge shamt+1, i.e. shamt+2 cycles after start is sampled.
  - shamt=0 → done 2 cycles after accept, out=in.
  - Max (shamt=31) → 33 cycles.
- start while busy or in DONE: ignored, no queuing. in/shamt/arith may change freely after accept.
- out changes only on the SHIFT→DONE transition (or reset); stable during SHIFT.
- Arithmetic shift of a negative operand by WIDTH-1 yields all ones; logical shift yields 0 or 1.
- No overflow condition: count decrements from shamt to 0 exactly once per shifting cycle, never wraps.

Optional Feature:
Macro: SERIAL_RIGHT_SHIFTER_FAST_EN
- Defined: in SHIFT, if count>=4, shift by 4 (fill replicated 4 times) and count <= count-4; otherwise shift by 1 as normal.
  - Shifting cycles = floor(shamt/4) + (shamt mod 4).
  - Example: shamt=31 → 7+3 = 10 shifting cycles, done 12 cycles after accept.
  - Results are bit-identical to the non-fast build.
- Not defined: strictly 1 bit per cycle, latency as in Behaviour.
- Handshake, reset and out-hold rules are identical in both builds.

Test Plan:
1. Logical shift: in=0xF0000000, shamt=4, arith=0, start pulse → busy for 5 cycles, done 6 cycles after accept, out=0x0F000000, ready back next cycle.
2. Arithmetic shift: in=0x80000000, shamt=31, arith=1 → out=0xFFFFFFFF, done 33 cycles after accept (FAST build: 12 cycles); with arith=0 → out=0x00000001.
3. Zero shift: in=0x12345678, shamt=0 → done 2 cycles after accept, out=0x12345678. Then start held high every cycle → next accept only once ready=1; extra starts ignored.
4. Start during busy: accept in=0xFFFF0000, shamt=8, arith=0. Assert start with in=0x1, shamt=1 mid-shift → ignored; out=0x00FFFF00, exactly one done pulse.
5. Reset mid-op: accept shamt=20, assert reset at cycle 5 → immediately ready=1, busy=0, done=0, out=0. No done pulse afterward; a new request with in=0x100, shamt=8 → out=0x1.
6. Random regression: 1000 random in/shamt/arith vs reference (logical >> or signed >>>) in both macro builds. Checks: out match, done pulse width=1, out stable between done pulses.
